// File: rtl/alu_rr_arbiter.sv
// Shared ALU with a round-robin front end.
// Requesters are arbitrated, accepted operations run through a 2-stage registered
// pipeline, and each result is returned tagged with the owning requester's index.
module alu_rr_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          hold,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [3*N_REQ-1:0]            req_ctrl,
   input  logic [DATA_WIDTH*N_REQ-1:0]   req_in0,
   input  logic [DATA_WIDTH*N_REQ-1:0]   req_in1,
   output logic [N_REQ-1:0]              resp_valid,
   output logic [ID_WIDTH-1:0]           resp_id,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_err,
   output logic                          busy
);

   localparam int unsigned CTRL_W = 3;

   // ALU control codes (team standard)
   localparam logic [CTRL_W-1:0] OP_PASS = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] OP_EQ   = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] OP_LT   = CTRL_W'(4);
   localparam logic [CTRL_W-1:0] OP_GE   = CTRL_W'(5);

   // Round-robin pointer: index of the most recent winner
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

   // Stage 1: accepted operation feeding the ALU
   logic                  s1_valid_q, s1_valid_d;
   logic [CTRL_W-1:0]     s1_ctrl_q, s1_ctrl_d;
   logic [DATA_WIDTH-1:0] s1_in0_q, s1_in0_d;
   logic [DATA_WIDTH-1:0] s1_in1_q, s1_in1_d;
   logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;

   // Stage 2: registered response
   logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;
   logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;
   logic                  busy_q, busy_d;

   // Arbitration and ALU intermediates
   int unsigned           scan_idx;
   logic                  grant_c;
   logic [ID_WIDTH-1:0]   grant_id_c;
   logic [CTRL_W-1:0]     sel_ctrl_c;
   logic [DATA_WIDTH-1:0] sel_in0_c, sel_in1_c;
   logic                  lt_c;
   logic [DATA_WIDTH-1:0] alu_res_c;
   logic                  alu_err_c;

   // Round-robin search starting just after the last winner, suppressed by hold
   always_comb begin
      grant_c    = 1'b0;
      grant_id_c = ptr_q;
      scan_idx   = 0;
      if (!hold) begin
         for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % N_REQ;
            if (!grant_c && req_valid[ID_WIDTH'(scan_idx)]) begin
               grant_c    = 1'b1;
               grant_id_c = ID_WIDTH'(scan_idx);
            end
         end
      end
   end

   // One-hot accept to the winner; winner only exists when its valid is high
   always_comb begin
      req_ready = '0;
      if (grant_c) begin
         req_ready[grant_id_c] = 1'b1;
      end
   end

   // Pick the winner's payload out of the flattened request buses
   always_comb begin
      sel_ctrl_c = req_ctrl[grant_id_c*CTRL_W +: CTRL_W];
      sel_in0_c  = req_in0[grant_id_c*DATA_WIDTH +: DATA_WIDTH];
      sel_in1_c  = req_in1[grant_id_c*DATA_WIDTH +: DATA_WIDTH];
   end

   // Pointer update and stage-1 load on a transfer; payload holds when idle
   always_comb begin
      ptr_d      = ptr_q;
      s1_valid_d = grant_c;
      s1_ctrl_d  = s1_ctrl_q;
      s1_in0_d   = s1_in0_q;
      s1_in1_d   = s1_in1_q;
      s1_id_d    = s1_id_q;
      if (grant_c) begin
         ptr_d     = grant_id_c;
         s1_ctrl_d = sel_ctrl_c;
         s1_in0_d  = sel_in0_c;
         s1_in1_d  = sel_in1_c;
         s1_id_d   = grant_id_c;
      end
   end

   // ALU datapath driven by stage 1; codes 6 and 7 are flagged illegal
   always_comb begin
      alu_res_c = '0;
      alu_err_c = 1'b0;
      lt_c      = $signed(s1_in0_q) < $signed(s1_in1_q);
      case (s1_ctrl_q)
         OP_PASS: alu_res_c = s1_in0_q;
         OP_ADD:  alu_res_c = s1_in0_q + s1_in1_q;
         OP_SUB:  alu_res_c = s1_in0_q - s1_in1_q;
         OP_EQ:   alu_res_c = DATA_WIDTH'(s1_in0_q == s1_in1_q);
         OP_LT:   alu_res_c = DATA_WIDTH'(lt_c);
         OP_GE:   alu_res_c = DATA_WIDTH'(!lt_c);
         default: alu_err_c = 1'b1;
      endcase
   end

   // Stage 2: one-cycle strobe to the owner; data/id hold between results
   always_comb begin
      resp_valid_d = '0;
      resp_err_d   = 1'b0;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      if (s1_valid_q) begin
         resp_valid_d[s1_id_q] = 1'b1;
         resp_id_d             = s1_id_q;
         resp_err_d            = alu_err_c;
         resp_data_d           = alu_err_c ? '0 : alu_res_c;
      end
      busy_d = s1_valid_d | (|resp_valid_d);
   end

   // State registers; reset discards everything in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q        <= ID_WIDTH'(N_REQ - 1);
         s1_valid_q   <= 1'b0;
         s1_ctrl_q    <= '0;
         s1_in0_q     <= '0;
         s1_in1_q     <= '0;
         s1_id_q      <= '0;
         resp_valid_q <= '0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         s1_valid_q   <= s1_valid_d;
         s1_ctrl_q    <= s1_ctrl_d;
         s1_in0_q     <= s1_in0_d;
         s1_in1_q     <= s1_in1_d;
         s1_id_q      <= s1_id_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;

endmodule
